fuzz_stim_driver: RTL and testbench
===================================

Name: fuzz_stim_driver

Overview:
- Stimulus-and-response harness for fuzz-generated DUTs that have one clock, one signed 6-bit data input and a 1-bit registered output.
- Drives the DUT input from a Galois LFSR for a programmed number of vectors.
- Compacts the DUT's 1-bit output into a MISR signature.
- Sits beside the DUT in the fuzz top level; signatures from different synthesis flows are compared to expose miscompiles.

Parameters:
- STIM_W, 6, stimulus width (DUT input width, signed)
- LFSR_W, 16, stimulus LFSR width
- LFSR_POLY, 16'hB400, Galois right-shift feedback mask
- SEED, 16'hACE1, LFSR load value at start; zero is forced to 1
- SIG_W, 16, signature width
- SIG_POLY, 16'h1021, MISR feedback mask
- CNT_W, 8, vector counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a run; sampled in IDLE only
- num_vec  in  CNT_W  vectors per run, unsigned; sampled with start
- stim_o  out  STIM_W  signed stimulus to the DUT data input
- stim_valid  out  1  stim_o carries a live vector this cycle
- resp_i  in  1  DUT output (y)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the signature is final
- signature  out  SIG_W  MISR contents; held stable outside busy
- vec_count  out  CNT_W  vectors issued in the current or last run

Behaviour:
- Reset, async on rst high, all outputs 0: stim_o, stim_valid, busy, done, signature, vec_count; state IDLE.
- Reset mid-run: the run is aborted with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE with start=1 and num_vec!=0:
  - LFSR <= SEED (1 if SEED==0); signature <= 0; vec_count <= 0; go to RUN.
- IDLE with start=1 and num_vec==0:
  - signature <= 0, vec_count <= 0, go directly to DONE.
- RUN, every cycle:
  - stim_o = LFSR[STIM_W-1:0]; stim_valid = 1.
  - LFSR advances: next = (L>>1) ^ (L[0] ? LFSR_POLY : 0).
  - vec_count increments.
  - When vec_count reaches num_vec-1, go to DRAIN next.
- stim_o/stim_valid are registered: the vector is visible in the same cycle the state is RUN.
- Capture timing: the DUT has 1-cycle latency.
  - Capture enable = stim_valid delayed one cycle.
  - MISR update when enabled: sig <= (sig<<1) ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ {{SIG_W-1{1'b0}}, resp_i}.
- DRAIN: one cycle.
  - stim_valid=0; stim_o holds its last value.
  - Captures the response to the final vector; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Exactly num_vec responses are captured per run.
- num_vec is latched at start; changes during busy have no effect.
- start during RUN/DRAIN/DONE is ignored (no queueing).
- vec_count saturates at num_vec; it never wraps within a run.
- signature and vec_count keep their final values until the next accepted start.

Optional Feature:
- Macro FUZZ_SEED_PORT_EN.
- Defined:
  - adds input seed_i [LFSR_W-1:0], sampled with start and used in place of SEED.
  - seed_i==0 is forced to 1.
- Undefined: no seed_i port; SEED parameter only.

Decomposition:
- Shared package fuzz_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default LFSR_POLY, SIG_POLY and SEED constants
  - a function lfsr_step(value, poly)
- One sub-module: fuzz_misr.
  - Inputs: clk, rst, clr, en, din.
  - Output: sig.
  - Parameterised by SIG_W and SIG_POLY.

Test Plan:
- Reset, then start with num_vec=3 and SEED default:
  - stim_o sequence -31 (6'h21), -16 (6'h30), then the next LFSR value.
  - stim_valid high exactly 3 cycles; done pulses 2 cycles after the last valid; vec_count=3.
- resp_i tied 1:
  - num_vec=1 gives signature 16'h0001; num_vec=2 gives 16'h0003; num_vec=0 gives signature 0 with done one cycle after start.
- resp_i tied 0, num_vec=200: signature=16'h0000, vec_count=200, busy high 201 cycles.
- Assert rst for one cycle in the middle of a 50-vector run:
  - all outputs 0 immediately (asynchronously); no done pulse.
  - A fresh start reproduces the clean-run signature.
- start pulses during RUN and num_vec changed mid-run: no effect on vector count or signature.
- With FUZZ_SEED_PORT_EN defined:
  - seed_i=0 behaves as seed 1 (first stim_o=6'h01).
  - seed_i=16'hACE1 matches the default-SEED signature.

Source files
------------

// File: rtl/fuzz_pkg.sv
// -----------------------------------------------------------------------------
// fuzz_pkg
// Shared definitions for the fuzz stimulus/response harness:
//   - state_t          : controller states (IDLE, RUN, DRAIN, DONE)
//   - DEF_LFSR_POLY    : default Galois right-shift feedback mask for stimulus
//   - DEF_SIG_POLY     : default MISR feedback mask
//   - DEF_SEED         : default stimulus LFSR load value
//   - lfsr_step()      : one Galois right-shift step, width-agnostic up to
//                        LFSR_MAX_W bits (callers zero-extend and truncate)
// -----------------------------------------------------------------------------
package fuzz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          LFSR_MAX_W    = 32;
  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_SIG_POLY  = 16'h1021;
  localparam logic [15:0] DEF_SEED      = 16'hACE1;

  // Zero-extended upper bits stay zero through the shift, so a narrower
  // register can use this step and keep only its low bits.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] value,
    input logic [LFSR_MAX_W-1:0] poly
  );
    lfsr_step = (value >> 1) ^ (value[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// -----------------------------------------------------------------------------
// fuzz_misr
// Single-input MISR that compacts a 1-bit response stream into a signature.
// Update when en: sig <= (sig<<1) ^ (sig[MSB] ? SIG_POLY : 0) ^ din.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset (sig -> 0)
//   clr  in   synchronous clear to 0, wins over en
//   en   in   capture enable
//   din  in   response bit
//   sig  out  signature register
// -----------------------------------------------------------------------------
module fuzz_misr
  import fuzz_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = DEF_SIG_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0] s,
    input logic             b
  );
    misr_step = {s[SIG_W-2:0], 1'b0}
              ^ (s[SIG_W-1] ? SIG_POLY : '0)
              ^ {{(SIG_W-1){1'b0}}, b};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/fuzz_stim_driver.sv
// -----------------------------------------------------------------------------
// fuzz_stim_driver
// Stimulus-and-response harness placed beside a fuzz-generated DUT (one clock,
// signed STIM_W-bit input, 1-bit registered output). A run drives num_vec
// vectors from a Galois LFSR and compacts the DUT responses into a MISR
// signature, so different synthesis flows can be compared by signature.
//
// Optional build macro FUZZ_SEED_PORT_EN: adds input seed_i, sampled with
// start and used in place of the SEED parameter (zero forced to 1).
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset; aborts a run, no done
//   start       in   one-cycle run request, honoured in IDLE only
//   num_vec     in   vectors per run (unsigned), sampled with start
//   seed_i      in   (FUZZ_SEED_PORT_EN only) LFSR seed, sampled with start
//   stim_o      out  signed stimulus to the DUT data input
//   stim_valid  out  stim_o carries a live vector this cycle
//   resp_i      in   DUT output, one cycle behind stim_o
//   busy        out  high in RUN and DRAIN
//   done        out  one-cycle pulse when the signature is final
//   signature   out  MISR contents, stable outside busy
//   vec_count   out  vectors issued in the current or last run
// -----------------------------------------------------------------------------
module fuzz_stim_driver
  import fuzz_pkg::*;
#(
  parameter int                STIM_W    = 6,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
  parameter int                SIG_W     = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY  = DEF_SIG_POLY,
  parameter int                CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic        [CNT_W-1:0]  num_vec,
`ifdef FUZZ_SEED_PORT_EN
  input  logic        [LFSR_W-1:0] seed_i,
`endif
  output logic signed [STIM_W-1:0] stim_o,
  output logic                     stim_valid,
  input  logic                     resp_i,
  output logic                     busy,
  output logic                     done,
  output logic        [SIG_W-1:0]  signature,
  output logic        [CNT_W-1:0]  vec_count
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [LFSR_W-1:0]        lfsr_q;
  logic [LFSR_W-1:0]        lfsr_next;
  logic [LFSR_W-1:0]        seed_sel;
  logic [LFSR_W-1:0]        seed_eff;
  logic [LFSR_W-1:0]        seed_adv;
  logic [CNT_W-1:0]         nv_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [STIM_W-1:0] stim_p0;
  logic                     vld_p0;
  logic                     vld_p1;
  logic                     go_run;
  logic                     go_zero;
  logic                     last_vec;

`ifdef FUZZ_SEED_PORT_EN
  assign seed_sel = seed_i;
`else
  assign seed_sel = SEED;
`endif

  // An all-zero Galois LFSR is stuck at zero, so a zero seed becomes 1.
  assign seed_eff  = (seed_sel == '0) ? LFSR_ONE : seed_sel;
  assign seed_adv  = LFSR_W'(lfsr_step(LFSR_MAX_W'(seed_eff), LFSR_MAX_W'(LFSR_POLY)));
  assign lfsr_next = LFSR_W'(lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(LFSR_POLY)));

  // cnt_q counts vectors already shown before this cycle, so the vector on
  // stim_o now is the last one when cnt_q == num_vec-1.
  assign last_vec = (cnt_q == (nv_q - CNT_ONE));

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    go_run  = 1'b0;
    go_zero = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            go_run  = 1'b1;
            state_d = RUN;
          end else begin
            go_zero = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_vec) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: stimulus issue (vector visible while state is RUN) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= '0;
      nv_q    <= '0;
      cnt_q   <= '0;
      stim_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (go_run) begin
      // First vector is the seed itself; the register holds the one after.
      stim_p0 <= $signed(seed_eff[STIM_W-1:0]);
      lfsr_q  <= seed_adv;
      vld_p0  <= 1'b1;
      nv_q    <= num_vec;
      cnt_q   <= '0;
    end else if (go_zero) begin
      nv_q  <= num_vec;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      if (cnt_q != nv_q) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (last_vec) begin
        vld_p0 <= 1'b0;
      end else begin
        stim_p0 <= $signed(lfsr_q[STIM_W-1:0]);
        lfsr_q  <= lfsr_next;
      end
    end
  end

  // ---- stage p1: response capture, one cycle behind stimulus ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  fuzz_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (go_run | go_zero),
    .en  (vld_p1),
    .din (resp_i),
    .sig (signature)
  );

  assign stim_o     = stim_p0;
  assign stim_valid = vld_p0;
  assign vec_count  = cnt_q;

endmodule

// File: tb/tb_fuzz_stim_driver.sv
module tb_fuzz_stim_driver;

  logic               clk;
  logic               rst;
  logic               start;
  logic        [7:0]  num_vec;
`ifdef FUZZ_SEED_PORT_EN
  logic        [15:0] seed_i;
`endif
  logic signed [5:0]  stim_o;
  logic               stim_valid;
  logic               resp_i;
  logic               busy;
  logic               done;
  logic        [15:0] signature;
  logic        [7:0]  vec_count;

  // Stand-in DUT: mode 0 -> y=0, mode 1 -> y=1, mode 2 -> y = registered
  // parity of the stimulus (one cycle latency).
  int   mode;
  logic resp_reg;

  int checks = 0;
  int errors = 0;

  int         busy_cyc, vld_cyc, last_vld, done_at;
  logic [5:0] seq [3];
  logic [15:0] exp_sig;
  int         dn;

  fuzz_stim_driver dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vec    (num_vec),
`ifdef FUZZ_SEED_PORT_EN
    .seed_i     (seed_i),
`endif
    .stim_o     (stim_o),
    .stim_valid (stim_valid),
    .resp_i     (resp_i),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .vec_count  (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) resp_reg <= ^stim_o;
  assign resp_i = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : resp_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected signature from a behavioural walk of LFSR, stand-in DUT and MISR.
  function automatic logic [15:0] ref_sig(input logic [15:0] seed, input int n, input int m);
    logic [15:0] l;
    logic [15:0] s;
    logic [5:0]  v;
    logic        r;
    l = (seed == 16'h0) ? 16'h0001 : seed;
    s = 16'h0000;
    for (int k = 0; k < n; k++) begin
      v = l[5:0];
      case (m)
        0:       r = 1'b0;
        1:       r = 1'b1;
        default: r = ^v;
      endcase
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    end
    return s;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stim_o"},     {26'b0, stim_o}, 32'h0);
    chk({tag, "_stim_valid"}, {31'b0, stim_valid}, 32'h0);
    chk({tag, "_busy"},       {31'b0, busy}, 32'h0);
    chk({tag, "_done"},       {31'b0, done}, 32'h0);
    chk({tag, "_signature"},  {16'b0, signature}, 32'h0);
    chk({tag, "_vec_count"},  {24'b0, vec_count}, 32'h0);
  endtask

  // One run; i indexes cycles after the accepting edge (i=0 is first RUN).
  // With poke set, start and num_vec are disturbed mid-run and during DRAIN.
  task automatic do_run(input int n, input bit poke);
    busy_cyc = 0;
    vld_cyc  = 0;
    last_vld = -1;
    done_at  = -1;
    start    = 1'b1;
    num_vec  = n[7:0];
    tick();
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (stim_valid) begin
        if (vld_cyc < 3) seq[vld_cyc] = stim_o;
        vld_cyc++;
        last_vld = i;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_at = i;
        break;
      end
      start = 1'b0;
      if (poke && i == 5) begin
        start   = 1'b1;
        num_vec = 8'd7;
      end
      if (poke && i == 6) num_vec = 8'd200;
      if (poke && i == n) start = 1'b1;
      tick();
    end
    start = 1'b0;
    chk("done_seen", {31'b0, (done_at >= 0)}, 32'h1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    num_vec = 8'd0;
    mode    = 2;
`ifdef FUZZ_SEED_PORT_EN
    seed_i  = 16'hACE1;
`endif
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // n=3, parity responses: vectors 21,30,38 -> parities 0,0,1 -> sig 0001
    do_run(3, 1'b0);
    chk("n3_stim0", {26'b0, seq[0]}, 32'h21);
    chk("n3_stim1", {26'b0, seq[1]}, 32'h30);
    chk("n3_stim2", {26'b0, seq[2]}, 32'h38);
    chk("n3_valid_cycles", vld_cyc, 3);
    chk("n3_done_after_last_valid", done_at - last_vld, 2);
    chk("n3_busy_cycles", busy_cyc, 4);
    chk("n3_vec_count", {24'b0, vec_count}, 32'd3);
    chk("n3_signature", {16'b0, signature}, 32'h0001);
    chk("n3_sig_ref", {16'b0, ref_sig(16'hACE1, 3, 2)}, 32'h0001);
    tick();
    chk("n3_done_one_cycle", {31'b0, done}, 32'h0);
    chk("n3_idle_busy", {31'b0, busy}, 32'h0);
    chk("n3_sig_hold", {16'b0, signature}, 32'h0001);

    // resp tied 1
    mode = 1;
    do_run(1, 1'b0);
    chk("one_n1_signature", {16'b0, signature}, 32'h0001);
    tick();
    do_run(2, 1'b0);
    chk("one_n2_signature", {16'b0, signature}, 32'h0003);
    chk("one_n2_vec_count", {24'b0, vec_count}, 32'd2);
    tick();
    do_run(0, 1'b0);
    chk("one_n0_signature", {16'b0, signature}, 32'h0000);
    chk("one_n0_done_delay", done_at, 0);
    chk("one_n0_valid_cycles", vld_cyc, 0);
    chk("one_n0_vec_count", {24'b0, vec_count}, 32'd0);
    tick();
    do_run(5, 1'b0);
    chk("one_n5_signature", {16'b0, signature}, 32'h001F);
    tick();

    // resp tied 0, long run
    mode = 0;
    do_run(200, 1'b0);
    chk("zero_n200_signature", {16'b0, signature}, 32'h0000);
    chk("zero_n200_vec_count", {24'b0, vec_count}, 32'd200);
    chk("zero_n200_busy_cycles", busy_cyc, 201);
    chk("zero_n200_valid_cycles", vld_cyc, 200);
    tick();

    // parity responses, 50 vectors: clean run
    mode    = 2;
    exp_sig = ref_sig(16'hACE1, 50, 2);
    do_run(50, 1'b0);
    chk("p50_signature", {16'b0, signature}, {16'b0, exp_sig});
    chk("p50_vec_count", {24'b0, vec_count}, 32'd50);
    tick();

    // abort mid-run with an asynchronous reset pulse
    start   = 1'b1;
    num_vec = 8'd50;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("abort_busy_before", {31'b0, busy}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    dn  = 0;
    repeat (80) begin
      if (done || busy) dn++;
      tick();
    end
    chk("abort_no_done", dn, 0);
    do_run(50, 1'b0);
    chk("rerun_signature", {16'b0, signature}, {16'b0, exp_sig});
    chk("rerun_vec_count", {24'b0, vec_count}, 32'd50);
    tick();

    // start pulses and num_vec changes while busy are ignored
    do_run(50, 1'b1);
    chk("poke_valid_cycles", vld_cyc, 50);
    chk("poke_vec_count", {24'b0, vec_count}, 32'd50);
    chk("poke_signature", {16'b0, signature}, {16'b0, exp_sig});
    tick();
    chk("poke_no_restart", {31'b0, busy}, 32'h0);
    tick();

`ifdef FUZZ_SEED_PORT_EN
    seed_i = 16'h0000;
    do_run(2, 1'b0);
    chk("seed0_stim0", {26'b0, seq[0]}, 32'h01);
    chk("seed0_signature", {16'b0, signature}, {16'b0, ref_sig(16'h0000, 2, 2)});
    tick();
    seed_i = 16'hACE1;
    do_run(50, 1'b0);
    chk("seedport_signature", {16'b0, signature}, {16'b0, exp_sig});
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
